// File: rtl/core_boot_sequencer_pkg.sv
// Shared types and constants for the core boot sequencer: packet/memory
// request layouts, FSM state encoding, image selects and status magic words.
package core_boot_sequencer_pkg;

  typedef enum logic [2:0] {
    NET_OP_NULL  = 3'd0,
    NET_OP_INSTR = 3'd1,
    NET_OP_REG   = 3'd2,
    NET_OP_PC    = 3'd3,
    NET_OP_BAR   = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [9:0]  net_id;
    net_op_e     op;
    logic [4:0]  reserved;
    logic [31:0] net_data;
    logic [9:0]  net_addr;
  } net_packet_s;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
    logic [31:0] write_data;
  } mem_in_s;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_DMEM  = 4'd1,
    ST_DRAIN = 4'd2,
    ST_IMEM  = 4'd3,
    ST_REGS  = 4'd4,
    ST_BAR   = 4'd5,
    ST_PC    = 4'd6,
    ST_NUL   = 4'd7,
    ST_RUN   = 4'd8
  } boot_state_e;

  typedef enum logic [1:0] {
    IMG_DATA  = 2'd0,
    IMG_INSTR = 2'd1,
    IMG_REG   = 2'd2
  } img_sel_e;

  localparam logic [9:0]  BOOT_BAR_ADDR   = 10'd24;
  localparam logic [31:0] BOOT_NULL_DATA  = 32'hFFFF_FFFE;
  localparam logic [31:0] BOOT_PASS_MAGIC = 32'hC0FF_EEEE;
  localparam logic [31:0] BOOT_FAIL_MAGIC = 32'hDEAD_DEAD;
  localparam logic [31:0] BOOT_DONE_MAGIC = 32'h600D_BEEF;

  function automatic net_packet_s null_packet(input logic [9:0] id);
    net_packet_s p;
    p        = '0;
    p.net_id = id;
    p.op     = NET_OP_NULL;
    return p;
  endfunction

endpackage

// File: rtl/core_boot_sequencer_img_reader.sv
// boot_img_reader: walks image indices 0..N-1 while enabled and returns
// {valid, idx, data} aligned with the image word one cycle after each read.
module boot_img_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic [10:0] i_words,
  input  logic [39:0] i_img_data,
  output logic        o_rd,
  output logic [9:0]  o_addr,
  output logic        o_done,
  output logic        o_valid,
  output logic [9:0]  o_idx,
  output logic [39:0] o_data
);

  logic [10:0] r_cnt;
  logic [9:0]  r_idx;
  logic        r_valid;
  logic        w_more;

  // Comparing against N-1 keeps N=1024 clear of the 11-bit counter wrap.
  assign w_more  = (i_words != 11'd0) && (r_cnt <= (i_words - 11'd1));
  assign o_rd    = i_en & w_more & reset;
  assign o_done  = i_en & ~w_more;
  assign o_addr  = r_cnt[9:0];
  assign o_valid = r_valid & reset;
  assign o_idx   = r_idx;
  assign o_data  = i_img_data;

  // Read index counter and one-cycle-delayed valid/index tag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt   <= 11'd0;
      r_idx   <= 10'd0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= o_rd;
      r_idx   <= r_cnt[9:0];
      if (i_en && w_more) begin
        r_cnt <= r_cnt + 11'd1;
      end else begin
        r_cnt <= 11'd0;
      end
    end
  end

endmodule

// File: rtl/core_boot_sequencer.sv
// core_boot_sequencer: preloads data_mem, then streams INSTR/REG/BAR/PC/NULL
// packets to one core. Optional core status decode under CORE_BOOT_STATUS_EN.
module core_boot_sequencer
  import core_boot_sequencer_pkg::*;
#(
  parameter int          DMEM_WORDS_P = 1024,
  parameter int          IMEM_WORDS_P = 1024,
  parameter int          REG_WORDS_P  = 64,
  parameter logic [9:0]  NET_ID_P     = 10'd1,
  parameter logic [31:0] BAR_MASK_P   = 32'h2,
  parameter logic [31:0] BOOT_PC_P    = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  output logic        img_rd_o,
  output logic [1:0]  img_sel_o,
  output logic [9:0]  img_addr_o,
  input  logic [39:0] img_data_i,
  output mem_in_s     mem_port_o,
  output logic [31:0] mem_addr_o,
  output logic        select_o,
  output net_packet_s net_packet_o,
  output logic        busy_o,
`ifdef CORE_BOOT_STATUS_EN
  input  logic        core_mem_valid_i,
  input  logic [31:0] core_mem_addr_i,
  output logic        pass_o,
  output logic        fail_o,
  output logic        done_o,
`endif
  output logic        booted_o
);

  localparam logic [10:0] W_DMEM = 11'(DMEM_WORDS_P);
  localparam logic [10:0] W_IMEM = 11'(IMEM_WORDS_P);
  localparam logic [10:0] W_REG  = 11'(REG_WORDS_P);

  boot_state_e r_state;
  boot_state_e w_next;
  logic        w_load_en;
  logic [10:0] w_words;
  logic        w_rd;
  logic [9:0]  w_addr;
  logic        w_done;
  logic        w_valid;
  logic [9:0]  w_idx;
  logic [39:0] w_data;
  logic        w_unused;

  assign w_unused = ^w_data[39:38];

  boot_img_reader u_reader (
    .clk        (clk),
    .reset      (reset),
    .i_en       (w_load_en),
    .i_words    (w_words),
    .i_img_data (img_data_i),
    .o_rd       (w_rd),
    .o_addr     (w_addr),
    .o_done     (w_done),
    .o_valid    (w_valid),
    .o_idx      (w_idx),
    .o_data     (w_data)
  );

  // Phase size for the reader, selected by the current load state.
  always_comb begin
    w_load_en = 1'b0;
    w_words   = 11'd0;
    case (r_state)
      ST_DMEM: begin w_load_en = 1'b1; w_words = W_DMEM; end
      ST_IMEM: begin w_load_en = 1'b1; w_words = W_IMEM; end
      ST_REGS: begin w_load_en = 1'b1; w_words = W_REG;  end
      default: begin w_load_en = 1'b0; w_words = 11'd0;  end
    endcase
  end

  // Boot FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Boot FSM next-state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = start_i ? ST_DMEM : ST_IDLE;
      ST_DMEM:  w_next = w_done ? ST_DRAIN : ST_DMEM;
      ST_DRAIN: w_next = ST_IMEM;
      ST_IMEM:  w_next = w_done ? ST_REGS : ST_IMEM;
      ST_REGS:  w_next = w_done ? ST_BAR : ST_REGS;
      ST_BAR:   w_next = ST_PC;
      ST_PC:    w_next = ST_NUL;
      ST_NUL:   w_next = ST_RUN;
      ST_RUN:   w_next = ST_RUN;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Output decode; image words arrive one cycle after their read, so
  // writes and packets are formed from the aligned reader tag.
  always_comb begin
    img_rd_o     = 1'b0;
    img_sel_o    = IMG_DATA;
    img_addr_o   = 10'd0;
    mem_port_o   = '0;
    mem_addr_o   = 32'd0;
    select_o     = 1'b0;
    busy_o       = 1'b0;
    booted_o     = 1'b0;
    net_packet_o = null_packet(NET_ID_P);
    if (reset) begin
      img_rd_o   = w_rd;
      img_addr_o = w_addr;
      case (r_state)
        ST_DMEM: begin
          busy_o = 1'b1;
          if (w_valid) begin
            mem_port_o.valid      = 1'b1;
            mem_port_o.yumi       = 1'b1;
            mem_port_o.wen        = 1'b1;
            mem_port_o.write_data = w_data[31:0];
            mem_addr_o            = {20'd0, w_idx, 2'b00};
          end else begin
            mem_port_o = '0;
          end
        end
        ST_DRAIN: busy_o = 1'b1;
        ST_IMEM: begin
          busy_o    = 1'b1;
          select_o  = 1'b1;
          img_sel_o = IMG_INSTR;
          if (w_valid) begin
            net_packet_o.op       = NET_OP_INSTR;
            net_packet_o.net_data = {16'd0, w_data[15:0]};
            net_packet_o.net_addr = w_idx;
          end else begin
            net_packet_o = null_packet(NET_ID_P);
          end
        end
        ST_REGS: begin
          busy_o    = 1'b1;
          select_o  = 1'b1;
          img_sel_o = IMG_REG;
          if (w_valid) begin
            net_packet_o.op       = NET_OP_REG;
            net_packet_o.net_data = w_data[31:0];
            net_packet_o.net_addr = {4'd0, w_data[37:32]};
          end else begin
            net_packet_o = null_packet(NET_ID_P);
          end
        end
        ST_BAR: begin
          busy_o                = 1'b1;
          select_o              = 1'b1;
          net_packet_o.op       = NET_OP_BAR;
          net_packet_o.net_data = BAR_MASK_P;
          net_packet_o.net_addr = BOOT_BAR_ADDR;
        end
        ST_PC: begin
          busy_o                = 1'b1;
          select_o              = 1'b1;
          net_packet_o.op       = NET_OP_PC;
          net_packet_o.net_data = BOOT_PC_P;
          net_packet_o.net_addr = 10'd0;
        end
        ST_NUL: begin
          busy_o                = 1'b1;
          select_o              = 1'b1;
          net_packet_o.net_data = BOOT_NULL_DATA;
          net_packet_o.net_addr = BOOT_BAR_ADDR;
        end
        ST_RUN: begin
          select_o = 1'b1;
          booted_o = 1'b1;
        end
        default: busy_o = 1'b0;
      endcase
    end else begin
      net_packet_o = null_packet(NET_ID_P);
    end
  end

`ifdef CORE_BOOT_STATUS_EN
  logic r_pass;
  logic r_fail;
  logic r_done;
  logic r_halted;
  logic w_hit;

  assign w_hit  = core_mem_valid_i & select_o & ~r_halted;
  assign pass_o = r_pass;
  assign fail_o = r_fail;
  assign done_o = r_done;

  // Status pulses; fail/done latch halted and silence later pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
      r_done   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_pass   <= w_hit & (core_mem_addr_i == BOOT_PASS_MAGIC);
      r_fail   <= w_hit & (core_mem_addr_i == BOOT_FAIL_MAGIC);
      r_done   <= w_hit & (core_mem_addr_i == BOOT_DONE_MAGIC);
      r_halted <= r_halted | (w_hit & ((core_mem_addr_i == BOOT_FAIL_MAGIC) ||
                                       (core_mem_addr_i == BOOT_DONE_MAGIC)));
    end
  end
`endif

endmodule
